muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative 32-bit multiply/divide unit for the CPU datapath. It takes two operands from the register file read ports and a destination register index. It computes an unsigned or signed product, or a quotient and remainder, over a fixed number of cycles. It then presents the low result on a one-cycle write-back strobe that drives the register file write port (waddr/wdata/wen). The control unit stalls the pipeline while `busy` is high.

## Interface
- WIDTH, 32, operand and result width. Iteration count equals WIDTH.
- clk  input  1  single clock. All state updates on rising edge.
- rst  input  1  reset, synchronous, active-low. Sampled on rising edge of clk.
- start  input  1  request. Accepted only in IDLE.
- op  input  2  operation select: 00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed).
- src_a  input  WIDTH  multiplicand or dividend. Latched on accept.
- src_b  input  WIDTH  multiplier or divisor. Latched on accept.
- dest  input  5  destination register index. Latched on accept.
- busy  output  1  high from the cycle after accept through the write-back cycle.
- wb_en  output  1  one-cycle write strobe to the register file write enable.
- wb_addr  output  5  latched dest.
- wb_data  output  WIDTH  product low word, or quotient.
- hi_out  output  WIDTH  product high word, or remainder. Held until the next result.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 latches op, src_a, src_b and dest, clears the iteration counter, and moves to CALC.
  - For signed ops, the operand magnitudes are stored and the result signs are recorded.
- CALC: one iteration per cycle for WIDTH cycles. The counter runs 0..WIDTH-1, and the FSM moves to FIX when the count reaches WIDTH-1.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
- FIX: applies sign correction and loads wb_data and hi_out.
  - Signed multiply: the 2*WIDTH product is negated if the operand signs differ.
  - Signed divide: the quotient is negated if the operand signs differ, and the remainder takes the sign of the dividend.
- DONE: wb_en=1 for exactly one cycle, then the FSM returns to IDLE.
- Divide by zero (src_b=0) still takes the full latency. Results are wb_data=all ones and hi_out=src_a (raw dividend, no sign correction, both DIV and DIVU).
- Signed overflow: DIV of 0x80000000 by 0xFFFFFFFF gives wb_data=0x80000000 and hi_out=0. This must result from the magnitude datapath without special-casing.
- dest=0 is not filtered. wb_en pulses regardless, and the register-0 policy belongs to the decoder.
- Operands are latched. Changes on src_a, src_b, dest or op after accept have no effect.
- start while busy=1 is ignored and not queued.

## Timing
- Reset (rst=0 at an edge): next cycle has state=IDLE, busy=0, wb_en=0, wb_addr=0, wb_data=0, hi_out=0, counter=0. This applies in any state, including mid-CALC, and the in-flight operation is discarded with no wb_en.
- Latency, with start high in cycle 0 (IDLE):
  - Cycles 1..WIDTH: CALC.
  - Cycle WIDTH+1: FIX.
  - Cycle WIDTH+2 (34 for WIDTH=32): DONE.
- busy=1 in cycles 1..WIDTH+2 and 0 in IDLE.
- wb_en=1 only in cycle WIDTH+2. wb_data, wb_addr and hi_out are valid in that cycle and hold afterwards.
- Earliest next accept is cycle WIDTH+3 (back-to-back throughput: one op per WIDTH+3 cycles).
- busy is a registered state decode. wb_en is a registered state decode. No combinational path from start to any output.

## Test plan
- MULU 0xFFFFFFFF × 0xFFFFFFFF, dest=5, start cycle 0 -> cycle 34: wb_en=1, wb_addr=5, wb_data=0x00000001, hi_out=0xFFFFFFFE. wb_en=0 in cycles 33 and 35.
- MUL 0xFFFFFFFD (-3) × 0x00000007 -> wb_data=0xFFFFFFEB, hi_out=0xFFFFFFFF. MUL 0x80000000 × 0x80000000 -> wb_data=0, hi_out=0x40000000.
- DIV 0xFFFFFFF9 (-7) / 2 -> wb_data=0xFFFFFFFD, hi_out=0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 -> wb_data=0x7FFFFFFC, hi_out=1.
- DIVU 100 / 0 -> wb_data=0xFFFFFFFF, hi_out=0x64 at cycle 34. DIV 0x80000000 / 0xFFFFFFFF -> wb_data=0x80000000, hi_out=0.
- MULU 6×7 with start held high and src_a/src_b changed to 9/9 in cycles 1..34 -> single result 42, exactly one wb_en. Start in cycle 35 with 9×9 -> wb_data=81 at cycle 69.
- rst=0 for the edge ending cycle 10 of a DIVU -> cycle 11: busy=0, all outputs 0, no wb_en ever for that op. Start at cycle 12 -> result in cycle 46.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit for the CPU datapath.
// Shift-add multiply and restoring divide run on operand magnitudes.
// Signs are applied in a single fix-up cycle before the write-back strobe.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [4:0]       dest,
  output logic             busy,
  output logic             wb_en,
  output logic [4:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] hi_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               b_zero;
  logic [4:0]         dest_r;
  logic [WIDTH-1:0]   raw_a;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   in_mag_a;
  logic [WIDTH-1:0]   in_mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     partial;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand magnitudes, one multiply/divide iteration, and the sign fix-up values
  always_comb begin
    in_mag_a = (op[0] && src_a[WIDTH-1]) ? -src_a : src_a;
    in_mag_b = (op[0] && src_b[WIDTH-1]) ? -src_b : src_b;

    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    partial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = partial - {1'b0, mag_b};
    if (!diff[WIDTH]) begin
      div_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {partial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    prod_fix = neg_q ? -acc : acc;
    quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Control FSM with datapath registers; busy and wb_en are registered state decodes
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      b_zero  <= 1'b0;
      dest_r  <= '0;
      raw_a   <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      hi_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          wb_en <= 1'b0;
          if (start) begin
            is_div <= op[1];
            neg_q  <= op[0] & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_r  <= op[0] & src_a[WIDTH-1];
            b_zero <= (src_b == '0);
            dest_r <= dest;
            raw_a  <= src_a;
            mag_a  <= in_mag_a;
            mag_b  <= in_mag_b;
            acc    <= op[1] ? {{WIDTH{1'b0}}, in_mag_a} : {{WIDTH{1'b0}}, in_mag_b};
            count  <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (is_div) begin
            if (b_zero) begin
              wb_data <= '1;
              hi_out  <= raw_a;
            end else begin
              wb_data <= quot_fix;
              hi_out  <= rem_fix;
            end
          end else begin
            wb_data <= prod_fix[WIDTH-1:0];
            hi_out  <= prod_fix[2*WIDTH-1:WIDTH];
          end
          wb_addr <= dest_r;
          wb_en   <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          wb_en <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          wb_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with hand-computed results.
module tb_muldiv_unit;

  localparam logic [1:0] MULU = 2'b00;
  localparam logic [1:0] MUL  = 2'b01;
  localparam logic [1:0] DIVU = 2'b10;
  localparam logic [1:0] DIV  = 2'b11;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  dest;
  logic        busy;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] hi_out;

  int checkCount = 0;
  int passCount  = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .dest    (dest),
    .busy    (busy),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .hi_out  (hi_out)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Presents a request for one cycle worth of sampling; call just after a falling edge
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] d);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    dest  = d;
  endtask

  // Runs one operation from an idle unit and checks strobe timing, busy and results
  task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d,
                       input logic [31:0] expLo, input logic [31:0] expHi);
    int pulses;
    int pulseCyc;
    logic [31:0] gotLo;
    logic [31:0] gotHi;
    logic [31:0] gotAddr;
    logic busy1;
    logic busy35;
    logic [31:0] holdLo;
    pulses   = 0;
    pulseCyc = -1;
    gotLo    = '0;
    gotHi    = '0;
    gotAddr  = '0;
    busy1    = 1'b0;
    busy35   = 1'b1;
    holdLo   = '0;
    @(negedge clk);
    applyStimulus(o, a, b, d);
    for (int cyc = 1; cyc <= 38; cyc++) begin
      @(negedge clk);
      if (wb_en) begin
        pulses++;
        pulseCyc = cyc;
        gotLo    = wb_data;
        gotHi    = hi_out;
        gotAddr  = 32'(wb_addr);
      end
      if (cyc == 1)  busy1  = busy;
      if (cyc == 35) busy35 = busy;
      if (cyc == 37) holdLo = wb_data;
      if (cyc == 1) begin
        start = 1'b0;
        op    = ~o;
        src_a = ~a;
        src_b = b + 32'd3;
        dest  = ~d;
      end
    end
    checkOutput({tag, ".pulses"},  32'(pulses), 32'd1);
    checkOutput({tag, ".wbCycle"}, 32'(pulseCyc), 32'd34);
    checkOutput({tag, ".wbData"},  gotLo, expLo);
    checkOutput({tag, ".hiOut"},   gotHi, expHi);
    checkOutput({tag, ".wbAddr"},  gotAddr, 32'(d));
    checkOutput({tag, ".busy1"},   32'(busy1), 32'd1);
    checkOutput({tag, ".busy35"},  32'(busy35), 32'd0);
    checkOutput({tag, ".hold"},    holdLo, expLo);
  endtask

  // Start held high with operands changing after accept, then a second op at cycle 35
  task automatic runHeldStart();
    int pulses;
    int firstCyc;
    int secondCyc;
    logic [31:0] firstLo;
    logic [31:0] secondLo;
    pulses    = 0;
    firstCyc  = -1;
    secondCyc = -1;
    firstLo   = '0;
    secondLo  = '0;
    @(negedge clk);
    applyStimulus(MULU, 32'd6, 32'd7, 5'd3);
    for (int cyc = 1; cyc <= 72; cyc++) begin
      @(negedge clk);
      if (wb_en) begin
        pulses++;
        if (cyc <= 35) begin
          firstCyc = cyc;
          firstLo  = wb_data;
        end else begin
          secondCyc = cyc;
          secondLo  = wb_data;
        end
      end
      if (cyc == 1) begin
        src_a = 32'd9;
        src_b = 32'd9;
      end
      if (cyc == 36) start = 1'b0;
    end
    checkOutput("held.pulses",    32'(pulses), 32'd2);
    checkOutput("held.firstCyc",  32'(firstCyc), 32'd34);
    checkOutput("held.firstData", firstLo, 32'd42);
    checkOutput("held.secondCyc", 32'(secondCyc), 32'd69);
    checkOutput("held.secondData", secondLo, 32'd81);
  endtask

  // Reset asserted mid-CALC discards the op; a fresh op afterwards completes normally
  task automatic runMidReset();
    int pulses;
    int pulseCyc;
    logic [31:0] gotLo;
    logic [31:0] gotHi;
    pulses   = 0;
    pulseCyc = -1;
    gotLo    = '0;
    gotHi    = '0;
    @(negedge clk);
    applyStimulus(DIVU, 32'd1000, 32'd3, 5'd12);
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(negedge clk);
      if (wb_en) begin
        pulses++;
        pulseCyc = cyc;
        gotLo    = wb_data;
        gotHi    = hi_out;
      end
      if (cyc == 1) start = 1'b0;
      if (cyc == 10) rst = 1'b0;
      if (cyc == 11) begin
        checkOutput("rstMid.busy",   32'(busy), 32'd0);
        checkOutput("rstMid.wbEn",   32'(wb_en), 32'd0);
        checkOutput("rstMid.wbData", wb_data, 32'd0);
        checkOutput("rstMid.hiOut",  hi_out, 32'd0);
        checkOutput("rstMid.wbAddr", 32'(wb_addr), 32'd0);
        rst = 1'b1;
      end
      if (cyc == 12) applyStimulus(DIVU, 32'd100, 32'd7, 5'd9);
      if (cyc == 13) start = 1'b0;
    end
    checkOutput("rstMid.pulses",  32'(pulses), 32'd1);
    checkOutput("rstMid.wbCycle", 32'(pulseCyc), 32'd46);
    checkOutput("rstMid.wbData2", gotLo, 32'd14);
    checkOutput("rstMid.hiOut2",  gotHi, 32'd2);
  endtask

  // Main sequence: reset state, arithmetic vectors, latching and reset scenarios
  initial begin
    rst   = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    src_a = '0;
    src_b = '0;
    dest  = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset.busy",   32'(busy), 32'd0);
    checkOutput("reset.wbEn",   32'(wb_en), 32'd0);
    checkOutput("reset.wbAddr", 32'(wb_addr), 32'd0);
    checkOutput("reset.wbData", wb_data, 32'd0);
    checkOutput("reset.hiOut",  hi_out, 32'd0);
    rst = 1'b1;

    runOp("muluMax",  MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'h00000001, 32'hFFFFFFFE);
    runOp("mulNeg",   MUL,  32'hFFFFFFFD, 32'h00000007, 5'd7,  32'hFFFFFFEB, 32'hFFFFFFFF);
    runOp("mulMin",   MUL,  32'h80000000, 32'h80000000, 5'd1,  32'h00000000, 32'h40000000);
    runOp("divNeg",   DIV,  32'hFFFFFFF9, 32'h00000002, 5'd30, 32'hFFFFFFFD, 32'hFFFFFFFF);
    runOp("divuBig",  DIVU, 32'hFFFFFFF9, 32'h00000002, 5'd31, 32'h7FFFFFFC, 32'h00000001);
    runOp("divuZero", DIVU, 32'd100,      32'd0,        5'd4,  32'hFFFFFFFF, 32'h00000064);
    runOp("divZero",  DIV,  32'hFFFFFFF9, 32'd0,        5'd6,  32'hFFFFFFFF, 32'hFFFFFFF9);
    runOp("divOvf",   DIV,  32'h80000000, 32'hFFFFFFFF, 5'd2,  32'h80000000, 32'h00000000);
    runOp("divPosNeg", DIV, 32'd7,        32'hFFFFFFFE, 5'd0,  32'hFFFFFFFD, 32'h00000001);

    runHeldStart();
    repeat (2) @(negedge clk);
    runMidReset();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
